lookahead_hash_stage: RTL and testbench
=======================================

Name: lookahead_hash_stage

Overview:
- Sits directly downstream of the 4-in/1-out input byte FIFO and upstream of the LZRW1 hash table and match logic.
- Consumes the FIFO's strobed byte stream, throttling it through the FIFO's stop-output input.
- Presents one 3-byte lookahead window per byte position, together with its registered 12-bit LZRW1 hash and stream position, under a valid/ready handshake.
- On flush, emits the final short tail windows.

Parameters:
HASH_BITS, 12, hash width; hash = bits [4+HASH_BITS-1:4] of product
POS_BITS, 16, width of stream position counter (wraps)
BUF_DEPTH, 8, skid buffer depth in bytes (power of 2)
SKID, 4, bytes the upstream FIFO may still deliver after stop is raised

Ports:
ClkxCI  in  1  clock, rising edge
RstxRI  in  1  reset, asynchronous, active-high
DInxDI  in  8  byte from input FIFO
InStrobexSI  in  1  DInxDI valid this cycle
StopInputxSO  out  1  registered; drives input FIFO StopOutputxSI
FlushxSI  in  1  one-cycle pulse: end of stream, asserted after last byte strobe
WinxDO  out  24  window {b0,b1,b2}; b0 (oldest) in [23:16]
HashxDO  out  HASH_BITS  hash of WinxDO
PosxDO  out  POS_BITS  stream position of b0
TailLenxDO  out  2  real bytes in window (3, 2 or 1)
ValidxSO  out  1  window/hash/pos valid
ReadyxSI  in  1  consumer accepts; transfer = ValidxSO & ReadyxSI
DonexSO  out  1  one-cycle pulse after last tail transfer

Behaviour:
- Reset (async): buffer empty, window count 0, state FILL, Pos 0.
  - All outputs 0: StopInputxSO, ValidxSO, DonexSO, WinxDO, HashxDO, PosxDO, TailLenxDO.
  - Reset mid-operation discards everything; ValidxSO falls without a clock edge.
- Skid buffer:
  - A byte strobed in cycle t is written at the end of t.
  - StopInputxSO(next) = (occupancy(next) >= BUF_DEPTH-SKID).
  - A strobe while the buffer is full drops the byte.
- Window: 3-byte shift register that is the output register.
  - Pop from the buffer when window count < 3, or when a transfer occurs in the same cycle.
  - Hash is computed from the next window value and registered with it.
  - Latency: byte strobed in t completes a window -> ValidxSO=1 in t+2.
  - Throughput: 1 window/cycle with ReadyxSI held high.
- Outputs are stable while ValidxSO=1 and ReadyxSI=0.
- Hash: x = (b0<<8)^(b1<<4)^b2, 16-bit; p = 40543*x, 32-bit unsigned; HashxDO = p[4+HASH_BITS-1:4].
- Position: PosxDO increments by 1 per transfer, mod 2^POS_BITS.
- States:
  - FILL: window count < 3, ValidxSO=0.
    - -> RUN when the window fills.
    - -> FLUSH when flush is pending and the buffer is empty.
  - RUN: ValidxSO=1, TailLenxDO=3.
    - On transfer with no byte available -> FILL.
    - Flush pending and buffer empty -> the current full window is still emitted normally, then -> FLUSH.
  - FLUSH: shift out the remaining bytes one per transfer.
    - Window is left-justified with zero fill.
    - TailLenxDO = remaining count.
    - HashxDO = 0.
    - -> DONE after the TailLen=1 transfer; if no bytes remain, -> DONE directly.
  - DONE: DonexSO=1 for one cycle; Pos cleared to 0; -> FILL.
- Flush rules:
  - FlushxSI is latched as pending in any state.
  - A flush while already pending is ignored.
  - Strobes in FLUSH/DONE are dropped.
- Simultaneous events:
  - Strobe and pop in the same cycle: occupancy unchanged.
  - Transfer and refill in the same cycle: ValidxSO stays 1.

Optional Feature:
LOOKAHEAD_OVERFLOW_DET_EN
- Defined:
  - Adds output OverflowxSO (1 bit, reset 0, registered).
  - Sticky set on any dropped byte (buffer-full strobe, or strobe in FLUSH/DONE); cleared only by reset.
  - Simulation also issues $error("-E- lookahead buffer overrun").
- Undefined: port and logic absent; bytes drop silently.

Test Plan:
1. Assert RstxRI mid-stream with ValidxSO=1 -> ValidxSO, StopInputxSO, PosxDO, WinxDO all 0 immediately, before the next clock edge.
2. ReadyxSI=1; strobe 0x61,0x62,0x63 in cycles 0-2 -> ValidxSO=1 in cycle 4; WinxDO=0x616263, HashxDO=0xABD, PosxDO=0, TailLenxDO=3.
3. ReadyxSI=0; FIFO model honours stop with 2-cycle latency; stream 16 bytes 0x00..0x0F.
   - StopInputxSO rises when occupancy reaches 4; no drops.
   - Then ReadyxSI=1 -> 14 windows, Pos 0..13, Win(n)={n,n+1,n+2}.
4. Bytes 0x10..0x13, then FlushxSI, ReadyxSI=1 -> windows in order:
   - Pos0: 0x101112, TailLen 3.
   - Pos1: 0x111213, TailLen 3.
   - Pos2: 0x121300, TailLen 2, Hash 0.
   - Pos3: 0x130000, TailLen 1, Hash 0.
   - Then DonexSO pulses for 1 cycle; the next window starts at Pos 0.
5. All-zero bytes with continuous ReadyxSI=1 -> HashxDO=0 and one transfer per cycle once filled, no bubbles.
6. With LOOKAHEAD_OVERFLOW_DET_EN; FIFO ignores stop, ReadyxSI=0; strobe 12 bytes back-to-back -> bytes 1-11 retained (3 in window + 8 in buffer), byte 12 dropped, OverflowxSO=1 the next cycle and stays 1.

Source files
------------

// File: rtl/lookahead_hash_stage.sv
// lookahead_hash_stage: skid-buffered byte intake feeding a 3-byte lookahead
// window with a registered LZRW1 hash and stream position, valid/ready output,
// and short tail windows on flush.
// Optional feature macro: LOOKAHEAD_OVERFLOW_DET_EN (adds sticky OverflowxSO).
module lookahead_hash_stage #(
  parameter int unsigned HASH_BITS = 12,
  parameter int unsigned POS_BITS  = 16,
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned SKID      = 4
) (
  input  logic                 ClkxCI,
  input  logic                 RstxRI,
  input  logic [7:0]           DInxDI,
  input  logic                 InStrobexSI,
  output logic                 StopInputxSO,
  input  logic                 FlushxSI,
  output logic [23:0]          WinxDO,
  output logic [HASH_BITS-1:0] HashxDO,
  output logic [POS_BITS-1:0]  PosxDO,
  output logic [1:0]           TailLenxDO,
  output logic                 ValidxSO,
  input  logic                 ReadyxSI,
  output logic                 DonexSO
`ifdef LOOKAHEAD_OVERFLOW_DET_EN
  ,
  output logic                 OverflowxSO
`endif
);

  localparam int unsigned PTR_BITS = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [7:0]           mem [BUF_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]  occ, occ_n;
  logic [1:0]           state, state_n;
  logic [1:0]           wcnt, wcnt_n;
  logic [23:0]          win, win_n;
  logic [HASH_BITS-1:0] hash, hash_n;
  logic [POS_BITS-1:0]  pos, pos_n;
  logic [1:0]           tail, tail_n;
  logic                 valid, valid_n;
  logic                 done, done_n;
  logic                 stop, stop_n;
  logic                 flush_pend, flush_pend_n;
  logic                 xfer, pop, wr_en, buf_empty, buf_full, accept;
  logic [7:0]           pop_byte;

  // LZRW1 hash of a window: ((b0<<8)^(b1<<4)^b2) * 40543, middle bits
  function automatic logic [HASH_BITS-1:0] hash_fn(input logic [23:0] w);
    logic [15:0] x;
    logic [31:0] p;
    x = {w[23:16], 8'h00} ^ {4'h0, w[15:8], 4'h0} ^ {8'h00, w[7:0]};
    p = 32'(x) * 32'd40543;
    return HASH_BITS'(p >> 4);
  endfunction

  // Buffer handshake: pop only from stored bytes, write unless full (a pop frees a slot)
  always_comb begin
    xfer      = valid & ReadyxSI;
    buf_empty = (occ == '0);
    buf_full  = (occ == CNT_BITS'(BUF_DEPTH));
    pop_byte  = mem[rd_ptr];
    pop       = 1'b0;
    case (state)
      S_FILL:  pop = ~buf_empty;
      S_RUN:   pop = xfer & ~buf_empty;
      default: pop = 1'b0;
    endcase
    accept = (state == S_FILL) || (state == S_RUN);
    wr_en  = InStrobexSI & accept & (~buf_full | pop);
    occ_n  = CNT_BITS'(occ + CNT_BITS'(wr_en) - CNT_BITS'(pop));
    stop_n = (occ_n >= CNT_BITS'(BUF_DEPTH - SKID));
  end

  // Next-state and window/output register values
  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    win_n        = win;
    hash_n       = hash;
    tail_n       = tail;
    valid_n      = valid;
    done_n       = 1'b0;
    flush_pend_n = flush_pend | FlushxSI;
    pos_n        = xfer ? POS_BITS'(pos + POS_BITS'(1)) : pos;
    case (state)
      S_FILL: begin
        if (pop) begin
          win_n  = {win[15:0], pop_byte};
          wcnt_n = 2'(wcnt + 2'd1);
          if (wcnt == 2'd2) begin
            state_n = S_RUN;
            valid_n = 1'b1;
            tail_n  = 2'd3;
            hash_n  = hash_fn(win_n);
          end
        end else if (flush_pend) begin
          if (wcnt == 2'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_FLUSH;
            valid_n = 1'b1;
            tail_n  = wcnt;
            hash_n  = '0;
            win_n   = (wcnt == 2'd2) ? {win[15:0], 8'h00} : {win[7:0], 16'h0000};
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (!buf_empty) begin
            win_n  = {win[15:0], pop_byte};
            hash_n = hash_fn(win_n);
          end else if (flush_pend) begin
            state_n = S_FLUSH;
            win_n   = {win[15:0], 8'h00};
            wcnt_n  = 2'd2;
            tail_n  = 2'd2;
            hash_n  = '0;
          end else begin
            state_n = S_FILL;
            win_n   = {8'h00, win[15:0]};
            wcnt_n  = 2'd2;
            valid_n = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        if (xfer) begin
          win_n  = {win[15:0], 8'h00};
          tail_n = 2'(tail - 2'd1);
          wcnt_n = 2'(tail - 2'd1);
          if (tail == 2'd1) begin
            state_n = S_DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n      = S_FILL;
        pos_n        = '0;
        wcnt_n       = 2'd0;
        win_n        = '0;
        hash_n       = '0;
        tail_n       = 2'd0;
        flush_pend_n = FlushxSI;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      state      <= S_FILL;
      wcnt       <= 2'd0;
      win        <= '0;
      hash       <= '0;
      pos        <= '0;
      tail       <= 2'd0;
      valid      <= 1'b0;
      done       <= 1'b0;
      stop       <= 1'b0;
      flush_pend <= 1'b0;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      win        <= win_n;
      hash       <= hash_n;
      pos        <= pos_n;
      tail       <= tail_n;
      valid      <= valid_n;
      done       <= done_n;
      stop       <= stop_n;
      flush_pend <= flush_pend_n;
      occ        <= occ_n;
      if (wr_en) wr_ptr <= PTR_BITS'(wr_ptr + PTR_BITS'(1));
      if (pop)   rd_ptr <= PTR_BITS'(rd_ptr + PTR_BITS'(1));
    end
  end

  // Skid buffer storage
  always_ff @(posedge ClkxCI) begin
    if (wr_en) mem[wr_ptr] <= DInxDI;
  end

`ifdef LOOKAHEAD_OVERFLOW_DET_EN
  logic drop;
  assign drop = InStrobexSI & ~wr_en;

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) OverflowxSO <= 1'b0;
    else if (drop) OverflowxSO <= 1'b1;
  end

  // Report every dropped byte in simulation
  always_ff @(posedge ClkxCI) begin
    if (!RstxRI) assert (!drop) else $error("-E- lookahead buffer overrun");
  end
`endif

  assign StopInputxSO = stop;
  assign WinxDO       = win;
  assign HashxDO      = hash;
  assign PosxDO       = pos;
  assign TailLenxDO   = tail;
  assign ValidxSO     = valid;
  assign DonexSO      = done;

endmodule

// File: tb/tb_lookahead_hash_stage.sv
// Directed testbench for lookahead_hash_stage (default parameters).
module tb_lookahead_hash_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        strobe = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        stop, valid, done;
  logic [23:0] win;
  logic [11:0] hash;
  logic [15:0] pos;
  logic [1:0]  tail;
`ifdef LOOKAHEAD_OVERFLOW_DET_EN
  logic        overflow;
`endif

  int checks = 0;
  int fails  = 0;

  lookahead_hash_stage dut (
    .ClkxCI      (clk),
    .RstxRI      (rst),
    .DInxDI      (din),
    .InStrobexSI (strobe),
    .StopInputxSO(stop),
    .FlushxSI    (flush),
    .WinxDO      (win),
    .HashxDO     (hash),
    .PosxDO      (pos),
    .TailLenxDO  (tail),
    .ValidxSO    (valid),
    .ReadyxSI    (ready),
    .DonexSO     (done)
`ifdef LOOKAHEAD_OVERFLOW_DET_EN
    ,
    .OverflowxSO (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference LZRW1 hash computed from the arithmetic definition
  function automatic logic [11:0] ref_hash(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    logic [15:0] x;
    logic [31:0] p;
    x = (16'(a) << 8) ^ (16'(b) << 4) ^ 16'(c);
    p = 32'(x) * 32'd40543;
    return p[15:4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; strobe = 1'b0; flush = 1'b0; ready = 1'b0; din = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if ({stop, valid, done, win, hash, pos, tail} !== '0) begin
      $display("FAIL reset_state: got %h expected 0", {stop, valid, done, win, hash, pos, tail});
      fails++;
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      strobe = 1'b1; din = 8'(8'h40 + i);
      step();
    end
    strobe = 1'b0;
    if ({valid, stop} !== 2'b11) begin
      $display("FAIL reset_precondition: valid,stop got %b expected 11", {valid, stop});
      fails++;
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if ({valid, stop, pos, win, hash, tail, done} !== '0) begin
      $display("FAIL async_reset: got %h expected 0", {valid, stop, pos, win, hash, tail, done});
      fails++;
    end
    checks++;
    step();
  endtask

  task automatic test_latency();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe = 1'b1; din = 8'(8'h61 + i);
      step();
    end
    strobe = 1'b0;
    if (valid !== 1'b0) begin
      $display("FAIL latency_early: valid got %b expected 0", valid);
      fails++;
    end
    checks++;
    step();
    if ({valid, win, hash, pos, tail} !== {1'b1, 24'h616263, 12'hABD, 16'd0, 2'd3}) begin
      $display("FAIL latency_window: got %h expected %h", {valid, win, hash, pos, tail},
               {1'b1, 24'h616263, 12'hABD, 16'd0, 2'd3});
      fails++;
    end
    checks++;
    step();
    if (valid !== 1'b0) begin
      $display("FAIL latency_drain: valid got %b expected 0", valid);
      fails++;
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    int  n = 0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic stop_seen = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (!stop_seen && stop) begin
        stop_seen = 1'b1;
        if (sent !== 7) begin
          $display("FAIL stop_rise: bytes sent got %0d expected 7", sent);
          fails++;
        end
        checks++;
      end
      strobe = (!s2 && sent < 16);
      din = 8'(sent);
      if (strobe) sent++;
      s2 = s1; s1 = stop;
      step();
    end
    if ({stop_seen, 8'(sent)} !== {1'b1, 8'd9}) begin
      $display("FAIL stop_hold: seen,sent got %h expected 109", {stop_seen, 8'(sent)});
      fails++;
    end
    checks++;
    ready = 1'b1;
    for (int c = 0; c < 80 && n < 14; c++) begin
      strobe = (!s2 && sent < 16);
      din = 8'(sent);
      if (strobe) sent++;
      if (valid) begin
        if ({win, hash, pos, tail} !== {8'(n), 8'(n + 1), 8'(n + 2),
             ref_hash(8'(n), 8'(n + 1), 8'(n + 2)), 16'(n), 2'd3}) begin
          $display("FAIL bp_window%0d: got %h expected %h", n, {win, hash, pos, tail},
                   {8'(n), 8'(n + 1), 8'(n + 2), ref_hash(8'(n), 8'(n + 1), 8'(n + 2)),
                    16'(n), 2'd3});
          fails++;
        end
        checks++;
        n++;
      end
      s2 = s1; s1 = stop;
      step();
    end
    strobe = 1'b0;
    if ({8'(n), valid} !== {8'd14, 1'b0}) begin
      $display("FAIL bp_count: windows,valid got %h expected 1c", {8'(n), valid});
      fails++;
    end
    checks++;
  endtask

  task automatic test_flush();
    logic [23:0] exp_win [4];
    logic [11:0] exp_hash [4];
    logic [1:0]  exp_tail [4];
    int n = 0;
    int done_cnt = 0;
    exp_win[0] = 24'h101112; exp_tail[0] = 2'd3; exp_hash[0] = ref_hash(8'h10, 8'h11, 8'h12);
    exp_win[1] = 24'h111213; exp_tail[1] = 2'd3; exp_hash[1] = ref_hash(8'h11, 8'h12, 8'h13);
    exp_win[2] = 24'h121300; exp_tail[2] = 2'd2; exp_hash[2] = 12'h000;
    exp_win[3] = 24'h130000; exp_tail[3] = 2'd1; exp_hash[3] = 12'h000;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      strobe = (c < 4);
      din    = 8'(8'h10 + c);
      flush  = (c == 4);
      if (done) done_cnt++;
      if (valid) begin
        if (n >= 4) begin
          $display("FAIL flush_extra: window %h beyond tail", win);
          fails++;
        end else if ({win, hash, pos, tail} !== {exp_win[n], exp_hash[n], 16'(n), exp_tail[n]}) begin
          $display("FAIL flush_window%0d: got %h expected %h", n, {win, hash, pos, tail},
                   {exp_win[n], exp_hash[n], 16'(n), exp_tail[n]});
          fails++;
        end
        checks++;
        n++;
      end
      step();
    end
    strobe = 1'b0; flush = 1'b0;
    if ({8'(n), 8'(done_cnt)} !== {8'd4, 8'd1}) begin
      $display("FAIL flush_done: windows,done_cycles got %h expected 0401", {8'(n), 8'(done_cnt)});
      fails++;
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      strobe = 1'b1; din = 8'(8'h20 + i);
      step();
    end
    strobe = 1'b0;
    for (int c = 0; c < 10 && !valid; c++) step();
    if ({valid, win, pos, tail} !== {1'b1, 24'h202122, 16'd0, 2'd3}) begin
      $display("FAIL flush_restart: got %h expected %h", {valid, win, pos, tail},
               {1'b1, 24'h202122, 16'd0, 2'd3});
      fails++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    ready = 1'b1;
    din = 8'h00;
    for (int c = 0; c < 16; c++) begin
      strobe = (c < 10);
      if (valid !== (c >= 4 && c <= 11)) begin
        $display("FAIL b2b_valid_c%0d: got %b expected %b", c, valid, (c >= 4 && c <= 11));
        fails++;
      end
      checks++;
      if (valid) begin
        if ({hash, pos} !== {12'h000, 16'(n)}) begin
          $display("FAIL b2b_window%0d: hash,pos got %h expected %h", n, {hash, pos},
                   {12'h000, 16'(n)});
          fails++;
        end
        checks++;
        n++;
      end
      step();
    end
    strobe = 1'b0;
  endtask

  task automatic test_overrun();
    int n = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      strobe = 1'b1; din = 8'(8'h21 + c);
`ifdef LOOKAHEAD_OVERFLOW_DET_EN
      if (overflow !== 1'b0) begin
        $display("FAIL overflow_early_c%0d: got %b expected 0", c, overflow);
        fails++;
      end
      checks++;
`endif
      step();
    end
    strobe = 1'b0;
`ifdef LOOKAHEAD_OVERFLOW_DET_EN
    for (int c = 0; c < 3; c++) begin
      if (overflow !== 1'b1) begin
        $display("FAIL overflow_sticky_c%0d: got %b expected 1", c, overflow);
        fails++;
      end
      checks++;
      step();
    end
`endif
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (valid) begin
        if ({win, pos, tail} !== {8'(8'h21 + n), 8'(8'h22 + n), 8'(8'h23 + n), 16'(n), 2'd3}) begin
          $display("FAIL overrun_window%0d: got %h expected %h", n, {win, pos, tail},
                   {8'(8'h21 + n), 8'(8'h22 + n), 8'(8'h23 + n), 16'(n), 2'd3});
          fails++;
        end
        checks++;
        n++;
      end
      step();
    end
    if (n !== 9) begin
      $display("FAIL overrun_count: windows got %0d expected 9", n);
      fails++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
